// File: rtl/ts19_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ts19_pkg
// Description : Shared constants and types for the TS19 instruction fetch
//               stage: address/instruction widths, reset PC, prefetch depth
//               and the fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ts19_pkg;

    localparam int              TS19_ADDR_W   = 16;
    localparam int              TS19_INST_W   = 32;
    localparam logic [15:0]     TS19_RESET_PC = 16'h0000;
    localparam int              TS19_DEPTH    = 2;

    // IDLE    : no request on the memory port
    // FETCH   : request outstanding, returned word will be queued
    // DISCARD : request outstanding, returned word is stale (redirect seen)
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

endpackage : ts19_pkg
`default_nettype wire

// File: rtl/ts19_inst_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ts19_inst_fifo
// Description : Two-entry {pc, inst} prefetch queue. Entry 0 is always the
//               head, so the head outputs come straight from registers.
//               Synchronous flush, simultaneous push/pop supported (also when
//               full).
// Ports       : clk, rst_n         - clock, asynchronous active-low reset
//               flush              - drop all entries at the edge
//               push/push_pc/push_inst - write a new entry
//               pop                - consume the head entry
//               head_pc/head_inst/head_valid - head entry
//               count              - current occupancy (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module ts19_inst_fifo #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [INST_W-1:0] push_inst,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_pc,
    output logic [INST_W-1:0] head_inst,
    output logic              head_valid,
    output logic [1:0]        count
);

    logic [ADDR_W-1:0] pc1;
    logic [INST_W-1:0] inst1;
    logic              pop_ok;
    logic              push_ok;
    logic [1:0]        count_next;

    assign pop_ok     = pop && (count != 2'd0);
    // A full queue only accepts a push when the head leaves in the same cycle.
    assign push_ok    = push && ((count != 2'd2) || pop_ok);
    assign head_valid = (count != 2'd0);

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 2'd1;
        end else if (!push_ok && pop_ok) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            head_pc   <= '0;
            head_inst <= '0;
            pc1       <= '0;
            inst1     <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            count <= count_next;
            if (pop_ok) begin
                if (count == 2'd2) begin
                    head_pc   <= pc1;
                    head_inst <= inst1;
                    if (push_ok) begin
                        pc1   <= push_pc;
                        inst1 <= push_inst;
                    end
                end else if (push_ok) begin
                    head_pc   <= push_pc;
                    head_inst <= push_inst;
                end
            end else if (push_ok) begin
                if (count == 2'd0) begin
                    head_pc   <= push_pc;
                    head_inst <= push_inst;
                end else begin
                    pc1   <= push_pc;
                    inst1 <= push_inst;
                end
            end
        end
    end

endmodule : ts19_inst_fifo
`default_nettype wire

// File: rtl/ts19_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ts19_fetch_unit
// Description : Instruction fetch stage for the TS19A64 core. Owns the
//               program counter, issues single-outstanding word reads over a
//               req/ack port, buffers returned words in a 2-entry prefetch
//               queue and hands them to decode over valid/ready. Redirects
//               flush the queue and restart fetch at a new address.
// Ports       : CLK, Reset_n       - clock, asynchronous active-low reset
//               imem_req/imem_addr/imem_ack/imem_rdata - memory read port
//               inst/inst_pc/inst_valid/inst_ready     - decode handshake
//               redirect/redirect_pc                   - flush and refetch
//               halt                                   - stop new requests
// Revision    : 1.0 - initial release
// ============================================================================
module ts19_fetch_unit
    import ts19_pkg::*;
#(
    parameter int                ADDR_W   = TS19_ADDR_W,
    parameter int                INST_W   = TS19_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = TS19_RESET_PC,
    parameter int                DEPTH    = TS19_DEPTH
) (
    input  logic              CLK,
    input  logic              Reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

    localparam logic [1:0] DEPTH_L = 2'(DEPTH);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_next;
    logic [1:0]        count;
    logic [1:0]        count_after;
    logic              mem_done;
    logic              keep;
    logic              pop;
    logic              space;
    logic              issue;

    // ack is only meaningful while a request is on the port
    assign mem_done = imem_ack && (state != ST_IDLE);
    assign pop      = inst_valid && inst_ready;

    // Occupancy the queue will have after this edge; a new request may only
    // start when it leaves room for the word that request will return.
    always_comb begin
        count_after = count;
        if (redirect) begin
            count_after = 2'd0;
        end else if (keep && !pop) begin
            count_after = count + 2'd1;
        end else if (!keep && pop) begin
            count_after = count - 2'd1;
        end
    end

    assign space = (count_after < DEPTH_L);

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!halt && space) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (mem_done) begin
                    state_next = (!halt && space) ? ST_FETCH : ST_IDLE;
                end else if (redirect) begin
                    state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (mem_done) begin
                    state_next = (!halt && space) ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- output / datapath control ----------------
    always_comb begin
        imem_req = (state != ST_IDLE);
        // A returning word is kept only in FETCH and only if no redirect
        // arrives with it.
        keep     = (state == ST_FETCH) && mem_done && !redirect;
        // A fresh request is launched whenever the port is free after this
        // edge and the FSM wants one; the address can only change then.
        issue    = (state_next == ST_FETCH) && ((state == ST_IDLE) || mem_done);
        if (redirect) begin
            pc_next = redirect_pc;
        end else if (keep) begin
            pc_next = fetch_pc + 1'b1;
        end else begin
            pc_next = fetch_pc;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
        end else begin
            fetch_pc <= pc_next;
            if (issue) begin
                imem_addr <= pc_next;
            end
        end
    end

    ts19_inst_fifo #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (Reset_n),
        .flush      (redirect),
        .push       (keep),
        .push_pc    (imem_addr),
        .push_inst  (imem_rdata),
        .pop        (inst_ready),
        .head_pc    (inst_pc),
        .head_inst  (inst),
        .head_valid (inst_valid),
        .count      (count)
    );

endmodule : ts19_fetch_unit
`default_nettype wire

// File: doc/ts19_fetch_unit.md
# ts19_fetch_unit

Instruction fetch stage that sits directly upstream of the TS19A64 core. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Returned 32-bit instructions are buffered in a 2-entry prefetch queue and presented to the core's decode stage with a valid/ready handshake. Branch/jump redirects from the core flush the queue and restart fetch at a new address.

## Interface
- ADDR_W, 16, instruction address width (word address)
- INST_W, 32, instruction width
- RESET_PC, 16'h0000, PC loaded on reset
- DEPTH, 2, prefetch queue entries (fixed at 2 for this revision)

- CLK  in  1  single clock, all state on rising edge
- Reset_n  in  1  one clock; reset is asynchronous and active-low
- imem_req  out  1  read request, held until imem_ack
- imem_addr  out  ADDR_W  read address, stable while imem_req high
- imem_ack  in  1  read complete; rdata valid this cycle; only meaningful with imem_req
- imem_rdata  in  INST_W  instruction word
- inst  out  INST_W  head-of-queue instruction
- inst_pc  out  ADDR_W  address of inst
- inst_valid  out  1  inst/inst_pc valid
- inst_ready  in  1  core accepts head entry when inst_valid & inst_ready
- redirect  in  1  one-cycle pulse: flush and refetch
- redirect_pc  in  ADDR_W  new fetch address, sampled with redirect
- halt  in  1  level: issue no new requests

## Operation
- Transfer: memory when imem_req & imem_ack; core when inst_valid & inst_ready.
- fetch_pc increments by 1 per completed transfer; wraps 16'hFFFF -> 16'h0000.
- Max one outstanding request. Request in flight reserves a queue slot: imem_req asserted only if occupancy + 1 <= DEPTH.
- imem_req/imem_addr never change while imem_req=1 and imem_ack=0 (no withdrawal, including on redirect or halt).
- FSM states: IDLE (no request), FETCH (request outstanding, data kept), DISCARD (request outstanding, data to be dropped after redirect).
  - IDLE -> FETCH: space available and halt=0.
  - FETCH -> FETCH: ack and space remains after the edge and halt=0 (addr advances, back-to-back).
  - FETCH -> IDLE: ack and (queue full after edge or halt=1).
  - FETCH -> DISCARD: redirect without ack same cycle.
  - DISCARD -> IDLE/FETCH: on ack; data dropped; next request (if any) uses redirected PC.
  - Reset from any state -> IDLE.
- Redirect: queue cleared at the edge; fetch_pc <= redirect_pc. Core pop in the same cycle is a valid consume. Ack in the same cycle: data dropped, state goes to IDLE/FETCH at redirect_pc (no DISCARD).
- Push and pop in same cycle at full: allowed, occupancy unchanged.
- halt: outstanding request completes and its data is queued; queue keeps draining.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst=0, inst_pc=0, inst_valid=0, fetch_pc=RESET_PC, state IDLE, queue empty.
- First imem_req=1 on first rising edge after Reset_n deasserts (halt=0).
- All outputs registered. ack at cycle N -> inst_valid at N+1 (empty queue).
- Zero-wait memory, inst_ready=1: one instruction per cycle sustained.
- Redirect at cycle N -> inst_valid=0 at N+1; new imem_addr=redirect_pc by N+1 if no request outstanding, else cycle after the discarded ack.

## Structure
- ts19_pkg: ADDR_W, INST_W, RESET_PC, fetch state enum (IDLE/FETCH/DISCARD).
- Sub-module ts19_inst_fifo: 2-entry {pc, inst} FIFO with synchronous flush, count output, push/pop same cycle.
- Top: FSM, fetch_pc, request control.

## Test plan
- Reset, halt=0, zero-wait memory returning rdata=addr|32'hA5000000, ready=1 -> addrs 0,1,2,... one per cycle; inst_pc 0,1,2 with matching inst.
- inst_ready=0 -> exactly 2 entries queued, imem_req low; raise ready -> requests resume at addr 2.
- 3-cycle ack latency, redirect to 16'h0040 during wait -> imem_addr held until ack, data dropped, next addr 16'h0040, no stale inst_valid.
- redirect and ack same cycle, redirect_pc=16'h0100 -> next request 16'h0100, acked data never appears.
- redirect_pc=16'hFFFE, free-running -> inst_pc FFFE, FFFF, 0000, 0001.
- Assert Reset_n low mid-request -> all outputs at reset values immediately (asynchronous), refetch from RESET_PC after release.
